activation_pingpong_buffer: RTL and testbench

ACTIVATION_PINGPONG_BUFFER -- requirements
Module: activation_pingpong_buffer

---
 rtl/strait_pkg.sv | 26 ++
 rtl/skew_delay_line.sv | 37 +++
 rtl/activation_pingpong_buffer.sv | 178 +++++++++++++++++
 tb/tb_activation_pingpong_buffer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strait_pkg.sv
// Shared defaults, read-FSM encoding and lane timing helpers for the
// activation ping-pong buffer.
package strait_pkg;

    localparam int DEFAULT_SYSTOLIC_SIZE    = 8;
    localparam int DEFAULT_ACTIVATION_WIDTH = 8;
    localparam int READ_LATENCY             = 1;
    localparam int OUTPUT_STAGES            = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } rd_state_t;

    function automatic int lane_offset(input int lane);
        return lane;
    endfunction

    // Draining covers the lane skew plus the read and output register stages,
    // so the last drain cycle coincides with the last lane's final valid row.
    function automatic int drain_cycles(input int size);
        return size - 1 + READ_LATENCY + OUTPUT_STAGES;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length delay line used to skew one activation lane; DELAY=0 is a
// plain wire.
module skew_delay_line #(
    parameter int DELAY = 0,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DELAY == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign dout = din;
    end else begin : g_pipe
        for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_d;
            logic [WIDTH-1:0] stage_q;
            if (gi == 0) begin : g_src
                assign stage_d = din;
            end else begin : g_src
                assign stage_d = g_stage[gi-1].stage_q;
            end
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end
        end
        assign dout = g_stage[DELAY-1].stage_q;
    end

endmodule

// File: rtl/activation_pingpong_buffer.sv
// Two-bank activation buffer: one bank fills while the other streams rows
// into a systolic array with a per-lane diagonal skew.
module activation_pingpong_buffer
    import strait_pkg::*;
#(
    parameter int SYSTOLIC_SIZE    = DEFAULT_SYSTOLIC_SIZE,
    parameter int ACTIVATION_WIDTH = DEFAULT_ACTIVATION_WIDTH,
    parameter int DEPTH            = SYSTOLIC_SIZE,
    parameter int ADDR_WIDTH       = $clog2(DEPTH)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        wr_en,
    input  logic [ADDR_WIDTH-1:0]                       wr_addr,
    input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]   activation_inputs_flat,
    input  logic                                        wr_commit,
    output logic                                        wr_ready,
    input  logic                                        start,
    output logic                                        busy,
    output logic [SYSTOLIC_SIZE-1:0]                    act_valid,
    output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]   activation_outputs_flat,
    output logic                                        done
);

    localparam int W          = ACTIVATION_WIDTH;
    localparam int FLAT_W     = SYSTOLIC_SIZE * ACTIVATION_WIDTH;
    localparam int BANK_ROWS  = 1 << ADDR_WIDTH;
    localparam int DRAIN_LAST = drain_cycles(SYSTOLIC_SIZE) - 1;
    localparam int CNT_W      = $clog2(DRAIN_LAST + 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      DRAIN_LAST_C = CNT_W'(DRAIN_LAST);
    localparam logic [CNT_W-1:0]      DONE_AT_C    = CNT_W'(DRAIN_LAST - 1);

    rd_state_t             state_reg;
    logic                  wr_sel_reg;
    logic                  rd_sel_reg;
    logic [1:0]            bank_full_reg;
    logic [1:0]            bank_full_next;
    logic [ADDR_WIDTH-1:0] rd_addr_reg;
    logic [CNT_W-1:0]      drain_cnt_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [FLAT_W-1:0]     mem [2*BANK_ROWS];
    logic [FLAT_W-1:0]     rd_data_reg;
    logic                  rd_vld_reg;
    logic                  write_ok;
    logic                  commit_ok;
    logic                  rd_en;
    logic                  bank_release;

    assign wr_ready     = !bank_full_reg[wr_sel_reg];
    assign write_ok     = rst_n && wr_en && wr_ready;
    assign commit_ok    = wr_commit && wr_ready;
    assign rd_en        = (state_reg == ST_STREAM);
    assign bank_release = (state_reg == ST_DRAIN) && (drain_cnt_reg == DRAIN_LAST_C);
    assign busy         = busy_reg;
    assign done         = done_reg;

    // Release and commit always target different banks, so both apply.
    always_comb begin
        bank_full_next = bank_full_reg;
        if (bank_release) begin
            bank_full_next[rd_sel_reg] = 1'b0;
        end
        if (commit_ok) begin
            bank_full_next[wr_sel_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_sel_reg    <= 1'b0;
            bank_full_reg <= '0;
        end else begin
            bank_full_reg <= bank_full_next;
            if (commit_ok) begin
                wr_sel_reg <= ~wr_sel_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[{wr_sel_reg, wr_addr}] <= activation_inputs_flat;
        end
        if (rd_en) begin
            rd_data_reg <= mem[{rd_sel_reg, rd_addr_reg}];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_reg <= 1'b0;
        end else begin
            rd_vld_reg <= rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            rd_sel_reg    <= 1'b0;
            rd_addr_reg   <= '0;
            drain_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (start && bank_full_reg[rd_sel_reg]) begin
                        state_reg   <= ST_STREAM;
                        rd_addr_reg <= '0;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (rd_addr_reg == ADDR_LAST) begin
                        state_reg     <= ST_DRAIN;
                        drain_cnt_reg <= '0;
                    end else begin
                        rd_addr_reg <= rd_addr_reg + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_reg == DRAIN_LAST_C) begin
                        state_reg  <= ST_IDLE;
                        busy_reg   <= 1'b0;
                        rd_sel_reg <= ~rd_sel_reg;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                        done_reg      <= (drain_cnt_reg == DONE_AT_C);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Each lane carries its valid bit through the skew; the output register
    // zeroes data whenever the lane is not valid.
    for (genvar gi = 0; gi < SYSTOLIC_SIZE; gi++) begin : g_lane
        logic [W:0]   lane_in;
        logic [W:0]   lane_out;
        logic         lane_vld_reg;
        logic [W-1:0] lane_data_reg;

        assign lane_in = {rd_vld_reg, rd_data_reg[gi*W +: W]};

        skew_delay_line #(
            .DELAY (lane_offset(gi)),
            .WIDTH (W + 1)
        ) u_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (lane_in),
            .dout  (lane_out)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                lane_vld_reg  <= 1'b0;
                lane_data_reg <= '0;
            end else begin
                lane_vld_reg  <= lane_out[W];
                lane_data_reg <= lane_out[W] ? lane_out[W-1:0] : '0;
            end
        end

        assign act_valid[gi]                   = lane_vld_reg;
        assign activation_outputs_flat[gi*W +: W] = lane_data_reg;
    end

endmodule

// File: tb/tb_activation_pingpong_buffer.sv
// Self-checking bench: timing-rule reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_activation_pingpong_buffer;

    localparam int S  = 4;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = 2;
    localparam int FW = S * W;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [FW-1:0] act_in;
    logic          wr_commit;
    logic          wr_ready;
    logic          start;
    logic          busy;
    logic [S-1:0]  act_valid;
    logic [FW-1:0] act_out;
    logic          done;

    activation_pingpong_buffer #(
        .SYSTOLIC_SIZE    (S),
        .ACTIVATION_WIDTH (W),
        .DEPTH            (D),
        .ADDR_WIDTH       (AW)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .wr_en                   (wr_en),
        .wr_addr                 (wr_addr),
        .activation_inputs_flat  (act_in),
        .wr_commit               (wr_commit),
        .wr_ready                (wr_ready),
        .start                   (start),
        .busy                    (busy),
        .act_valid               (act_valid),
        .activation_outputs_flat (act_out),
        .done                    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: banks as arrays, a stream as a start time t0 with
    // lane i of row r expected at t0+2+r+i, done at t0+D+S, bank freed at t0+D+S+1.
    logic [W-1:0] m_mem    [2][D][S];
    logic [W-1:0] m_stream [D][S];
    logic [1:0]   m_full;
    bit           m_wsel, m_rsel, m_active, model_on;
    int           m_t0;
    bit           m_rdy, m_acc, m_fin;
    logic         exp_wr_ready, exp_busy, exp_done;
    logic [S-1:0] exp_valid;
    logic [FW-1:0] exp_data;
    int           m_r;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < D; r++)
                for (int i = 0; i < S; i++)
                    m_mem[b][r][i] = '0;
        m_full = '0; m_wsel = 0; m_rsel = 0; m_active = 0; model_on = 0; m_t0 = 0;
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_active = 0; m_full = '0; m_wsel = 0; m_rsel = 0; model_on = 1;
        end else begin
            m_rdy = !m_full[m_wsel];
            m_acc = !m_active && start && m_full[m_rsel];
            m_fin = m_active && (cyc == m_t0 + D + S + 1);
            if (wr_en && m_rdy)
                for (int i = 0; i < S; i++) m_mem[m_wsel][wr_addr][i] = act_in[i*W +: W];
            if (wr_commit && m_rdy) begin
                m_full[m_wsel] = 1'b1;
                m_wsel = !m_wsel;
            end
            if (m_fin) begin
                m_full[m_rsel] = 1'b0;
                m_rsel = !m_rsel;
                m_active = 0;
            end
            if (m_acc) begin
                m_active = 1;
                m_t0 = cyc;
                for (int r = 0; r < D; r++)
                    for (int i = 0; i < S; i++) m_stream[r][i] = m_mem[m_rsel][r][i];
            end
        end
        exp_wr_ready = !m_full[m_wsel];
        exp_busy     = m_active;
        exp_done     = m_active && (cyc == m_t0 + D + S);
        exp_valid    = '0;
        exp_data     = '0;
        for (int i = 0; i < S; i++) begin
            m_r = cyc - m_t0 - 2 - i;
            if (m_active && m_r >= 0 && m_r < D) begin
                exp_valid[i]       = 1'b1;
                exp_data[i*W +: W] = m_stream[m_r][i];
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("m_wr_ready", int'(wr_ready), int'(exp_wr_ready));
            chk("m_busy", int'(busy), int'(exp_busy));
            chk("m_done", int'(done), int'(exp_done));
            chk("m_act_valid", int'(act_valid), int'(exp_valid));
            chk("m_act_data", int'(act_out), int'(exp_data));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [W-1:0] row0_lane0;

    task automatic write_row(input int r, input logic [FW-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(r); act_in = d;
        step();
        wr_en = 1'b0;
    endtask

    // mode 0: lane i of row r = 16*r+i; mode 1: random values below 0x80
    task automatic fill(input int mode);
        logic [FW-1:0] d;
        for (int r = 0; r < D; r++) begin
            for (int i = 0; i < S; i++)
                d[i*W +: W] = (mode == 0) ? W'(16 * r + i) : W'($urandom_range(0, 127));
            if (r == 0) row0_lane0 = d[W-1:0];
            write_row(r, d);
        end
    endtask

    task automatic commit();
        wr_commit = 1'b1; step(); wr_commit = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic wait_done(output bit found, output bit ready_low);
        found = 0; ready_low = 1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                found = 1;
                break;
            end
            if (wr_ready) ready_low = 0;
            step();
        end
    endtask

    int  vcnt [S];
    int  ndone, done_k, ff_seen, any_busy, any_valid;
    bit  found, low;
    logic [W-1:0] second_row0;

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; act_in = '0; wr_commit = 1'b0; start = 1'b0;
        repeat (2) step();
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_act_valid", int'(act_valid), 0);
        chk("rst_act_data", int'(act_out), 0);
        rst_n = 1'b1;
        step();

        $display("scenario basic stream");
        fill(0); commit(); do_start();
        for (int i = 0; i < S; i++) vcnt[i] = 0;
        ndone = 0; done_k = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            for (int i = 0; i < S; i++) if (act_valid[i]) vcnt[i]++;
            if (done) begin ndone++; done_k = k; end
            if (k == 5) begin
                chk("basic_lane2_row1", int'(act_out[2*W +: W]), 8'h12);
                chk("basic_lane2_valid", int'(act_valid[2]), 1);
            end
            if (k == 8) begin
                chk("basic_lane3_row3", int'(act_out[3*W +: W]), 8'h33);
                chk("basic_busy_last", int'(busy), 1);
            end
            if (k == 9) chk("basic_busy_off", int'(busy), 0);
        end
        chk("basic_done_cycle", done_k, 8);
        chk("basic_done_count", ndone, 1);
        for (int i = 0; i < S; i++) chk("basic_valid_count", vcnt[i], D);

        $display("scenario ping-pong");
        fill(1); commit(); do_start();
        fill(1); second_row0 = row0_lane0; commit();
        chk("pp_ready_after_commit", int'(wr_ready), 0);
        wait_done(found, low);
        chk("pp_done_seen", int'(found), 1);
        chk("pp_ready_held_low", int'(low), 1);
        chk("pp_ready_at_done", int'(wr_ready), 0);
        step();
        chk("pp_ready_rise", int'(wr_ready), 1);
        do_start();
        step(); step();
        chk("pp_second_row0", int'(act_out[W-1:0]), int'(second_row0));
        wait_done(found, low);
        chk("pp_second_done", int'(found), 1);
        repeat (2) step();

        $display("scenario gated write");
        fill(1); commit(); fill(1); commit();
        chk("gate_ready_low", int'(wr_ready), 0);
        for (int r = 0; r < D; r++) begin
            wr_commit = (r == D - 1);
            write_row(r, {FW{1'b1}});
        end
        wr_commit = 1'b0;
        ff_seen = 0; ndone = 0;
        for (int s = 0; s < 2; s++) begin
            do_start();
            for (int k = 1; k <= 12; k++) begin
                step();
                if (done) ndone++;
                for (int i = 0; i < S; i++)
                    if (act_valid[i] && act_out[i*W +: W] == 8'hFF) ff_seen++;
            end
        end
        chk("gate_no_ff", ff_seen, 0);
        chk("gate_two_streams", ndone, 2);

        $display("scenario start with no full bank");
        any_busy = 0; any_valid = 0; ndone = 0;
        do_start();
        for (int k = 0; k < 12; k++) begin
            if (busy) any_busy++;
            if (act_valid != '0) any_valid++;
            if (done) ndone++;
            step();
        end
        chk("nofull_busy", any_busy, 0);
        chk("nofull_valid", any_valid, 0);
        chk("nofull_done", ndone, 0);

        $display("scenario reset mid-stream");
        fill(1); commit(); do_start();
        repeat (3) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_valid", int'(act_valid), 0);
        chk("mrst_data", int'(act_out), 0);
        chk("mrst_wr_ready", int'(wr_ready), 1);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) ndone++;
            step();
        end
        chk("mrst_no_done", ndone, 0);
        fill(0); commit(); do_start();
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (done) ndone++;
            if (k == 5) chk("mrst_fresh_lane2_row1", int'(act_out[2*W +: W]), 8'h12);
        end
        chk("mrst_fresh_done", ndone, 1);

        $display("scenario commit on done cycle");
        fill(1); commit(); do_start();
        fill(1);
        wait_done(found, low);
        chk("sim_done_seen", int'(found), 1);
        wr_commit = 1'b1; step(); wr_commit = 1'b0;
        chk("sim_ready_after", int'(wr_ready), 1);
        do_start();
        chk("sim_start_accepted", int'(busy), 1);
        wait_done(found, low);
        chk("sim_second_done", int'(found), 1);
        repeat (2) step();

        $display("scenario random traffic");
        for (int n = 0; n < 3000; n++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = AW'($urandom_range(0, D - 1));
            act_in    = FW'($urandom);
            wr_commit = ($urandom_range(0, 7) == 0);
            start     = ($urandom_range(0, 5) == 0);
            rst_n     = ($urandom_range(0, 399) != 0);
            step();
        end
        wr_en = 1'b0; wr_commit = 1'b0; start = 1'b0; rst_n = 1'b1;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
